data_array_nway: RTL and testbench

Parametrised N-way cache data store, successor to the single-way byte-enabled array. Holds NUM_WAYS lines per set, with a registered 1-cycle read and write-first forwarding on same-cycle collisions. A sweep FSM clears the storage after reset and on flush, so the array can map to RAM instead of per-bit reset flops. Sits under the cache controller, beside the tag/valid arrays.

---
 rtl/data_array_nway_pkg.sv | 13 +
 rtl/data_array_nway_way_bank.sv | 22 ++
 rtl/data_array_nway.sv | 104 ++++++++++
 tb/tb_data_array_nway.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/data_array_nway_pkg.sv
// Shared sizing, state encoding and line type for the N-way cache data array.
package data_array_pkg;
  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int NUM_WAYS = 4;
  localparam int S_MASK   = 2 ** S_OFFSET;
  localparam int S_LINE   = 8 * S_MASK;
  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int S_WAY    = $clog2(NUM_WAYS);

  typedef enum logic {INIT, READY} dstate_t;
  typedef logic [S_LINE-1:0] line_t;
endpackage

// File: rtl/data_array_nway_way_bank.sv
// One way of line storage: byte-enabled synchronous write, asynchronous read.
module data_way_bank #(
  parameter int S_INDEX = 3,
  parameter int S_MASK  = 32
) (
  input  logic                  clk,
  input  logic [S_MASK-1:0]     wr_mask,
  input  logic [S_INDEX-1:0]    wr_index,
  input  logic [8*S_MASK-1:0]   wr_data,
  input  logic [S_INDEX-1:0]    rd_index,
  output logic [8*S_MASK-1:0]   rd_line
);
  // No reset on purpose so the array can map onto RAM; the sweep clears it.
  logic [8*S_MASK-1:0] mem [2**S_INDEX];

  always_ff @(posedge clk) begin
    for (int b = 0; b < S_MASK; b++)
      if (wr_mask[b]) mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
  end

  assign rd_line = mem[rd_index];
endmodule

// File: rtl/data_array_nway.sv
// N-way cache data store: sweep-cleared banks, 1-cycle registered read with write-first merge.
module data_array_nway #(
  parameter  int S_OFFSET = data_array_pkg::S_OFFSET,
  parameter  int S_INDEX  = data_array_pkg::S_INDEX,
  parameter  int NUM_WAYS = data_array_pkg::NUM_WAYS,
  localparam int S_MASK   = 2 ** S_OFFSET,
  localparam int S_LINE   = 8 * S_MASK,
  localparam int NUM_SETS = 2 ** S_INDEX,
  localparam int S_WAY    = $clog2(NUM_WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  output logic               busy,
  input  logic               rd_req,
  input  logic [S_INDEX-1:0] rd_index,
  input  logic [S_WAY-1:0]   rd_way,
  output logic               rd_valid,
  output logic [S_LINE-1:0]  rd_data,
  input  logic [S_MASK-1:0]  wr_mask,
  input  logic [S_INDEX-1:0] wr_index,
  input  logic [S_WAY-1:0]   wr_way,
  input  logic [S_LINE-1:0]  wr_data
);
  data_array_pkg::dstate_t state;
  logic [S_INDEX-1:0] cnt;
  logic sweep;

  assign sweep = (state == data_array_pkg::INIT);
  assign busy  = sweep;

  logic [NUM_WAYS-1:0][S_MASK-1:0] bank_mask;
  logic [NUM_WAYS-1:0][S_LINE-1:0] bank_line;
  logic [S_INDEX-1:0]              bank_index;
  logic [S_LINE-1:0]               bank_wdata;

  // While sweeping, every way of set[cnt] is written with zeros.
  always_comb begin
    bank_index = sweep ? cnt : wr_index;
    bank_wdata = sweep ? '0 : wr_data;
    for (int w = 0; w < NUM_WAYS; w++)
      bank_mask[w] = sweep ? '1 : ((S_WAY'(w) == wr_way) ? wr_mask : '0);
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    data_way_bank #(
      .S_INDEX (S_INDEX),
      .S_MASK  (S_MASK)
    ) u_bank (
      .clk      (clk),
      .wr_mask  (bank_mask[w]),
      .wr_index (bank_index),
      .wr_data  (bank_wdata),
      .rd_index (rd_index),
      .rd_line  (bank_line[w])
    );
  end

  logic [S_LINE-1:0] sel_line, merged;
  logic hit;

  assign sel_line = bank_line[rd_way];
  assign hit      = (wr_index == rd_index) && (wr_way == rd_way);

  always_comb begin
    merged = sel_line;
    for (int b = 0; b < S_MASK; b++)
      if (hit && wr_mask[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= data_array_pkg::INIT;
      cnt   <= '0;
    end else begin
      case (state)
        data_array_pkg::INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == S_INDEX'(NUM_SETS - 1)) begin
            state <= data_array_pkg::READY;
            cnt   <= '0;
          end
        end
        default: begin
          // A request in the flush cycle still completes; the sweep follows.
          if (flush) begin
            state <= data_array_pkg::INIT;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= !sweep && rd_req;
      if (!sweep && rd_req) rd_data <= merged;
    end
  end
endmodule

// File: tb/tb_data_array_nway.sv
// Randomized check of data_array_nway against a line-array model, plus directed literal cases.
module tb_data_array_nway;
  import data_array_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               flush = 1'b0;
  logic               busy;
  logic               rd_req = 1'b0;
  logic [S_INDEX-1:0] rd_index = '0;
  logic [S_WAY-1:0]   rd_way = '0;
  logic               rd_valid;
  line_t              rd_data;
  logic [S_MASK-1:0]  wr_mask = '0;
  logic [S_INDEX-1:0] wr_index = '0;
  logic [S_WAY-1:0]   wr_way = '0;
  line_t              wr_data = '0;

  data_array_nway dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .busy     (busy),
    .rd_req   (rd_req),
    .rd_index (rd_index),
    .rd_way   (rd_way),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr_mask  (wr_mask),
    .wr_index (wr_index),
    .wr_way   (wr_way),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  bit    chk_en = 1'b0;
  line_t mdl [NUM_SETS][NUM_WAYS];
  int    m_left;
  line_t exp_data;
  bit    exp_valid, exp_busy;

  task automatic chk(input string nm, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < NUM_WAYS; w++) mdl[s][w] = '0;
  endtask

  task automatic mdl_reset();
    mdl_clear();
    m_left    = NUM_SETS;
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_busy  = 1'b1;
  endtask

  // Drive one cycle of inputs, predict the outputs after the edge, advance.
  task automatic step(input bit f, input bit rr, input int ri, input int rw,
                      input logic [S_MASK-1:0] wm, input int wi, input int ww,
                      input line_t wd);
    line_t ln, n_data;
    bit    n_valid;
    flush = f; rd_req = rr;
    rd_index = S_INDEX'(ri); rd_way = S_WAY'(rw);
    wr_mask = wm; wr_index = S_INDEX'(wi); wr_way = S_WAY'(ww); wr_data = wd;
    n_data = exp_data;
    n_valid = 1'b0;
    if (m_left > 0) begin
      m_left--;
    end else begin
      if (rr) begin
        ln = mdl[ri][rw];
        if (wi == ri && ww == rw)
          for (int b = 0; b < S_MASK; b++) if (wm[b]) ln[8*b +: 8] = wd[8*b +: 8];
        n_data = ln;
        n_valid = 1'b1;
      end
      for (int b = 0; b < S_MASK; b++) if (wm[b]) mdl[wi][ww][8*b +: 8] = wd[8*b +: 8];
      if (f) begin
        mdl_clear();
        m_left = NUM_SETS;
      end
    end
    @(posedge clk);
    #1;
    exp_data  = n_data;
    exp_valid = n_valid;
    exp_busy  = (m_left > 0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, '0, 0, 0, '0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", line_t'(busy), line_t'(exp_busy));
      chk("rd_valid", line_t'(rd_valid), line_t'(exp_valid));
      chk("rd_data", rd_data, exp_data);
    end
  end

  initial begin
    int          n;
    bit          f, rr;
    int          ri, rw, wi, ww;
    logic [S_MASK-1:0] wm;
    line_t       wd;

    mdl_reset();
    #12;
    chk("rst_busy", line_t'(busy), line_t'(1));
    chk("rst_valid", line_t'(rd_valid), '0);
    chk("rst_data", rd_data, '0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk_en = 1'b1;

    n = 0;
    while (busy && n < 20) begin idle(); n++; end
    chk("init_len", line_t'(n), line_t'(NUM_SETS));

    step(1'b0, 1'b1, 6, 3, '0, 0, 0, '0);
    chk("init_read_valid", line_t'(rd_valid), line_t'(1));
    chk("init_read_zero", rd_data, '0);

    // Byte-masked partial write over a full line.
    step(1'b0, 1'b0, 0, 0, '1, 2, 1, {S_MASK{8'hAA}});
    step(1'b0, 1'b0, 0, 0, 32'h0000_000F, 2, 1, line_t'(32'h1122_3344));
    step(1'b0, 1'b1, 2, 1, '0, 0, 0, '0);
    chk("mask_lit", rd_data, {{(S_MASK-4){8'hAA}}, 32'h1122_3344});

    // Way isolation within set 5; set 4 untouched.
    for (int w = 0; w < NUM_WAYS; w++)
      step(1'b0, 1'b0, 0, 0, '1, 5, w, {S_MASK{8'(8'h10 + w)}});
    for (int w = 0; w < NUM_WAYS; w++) begin
      step(1'b0, 1'b1, 5, w, '0, 0, 0, '0);
      chk("way_lit", rd_data, {S_MASK{8'(8'h10 + w)}});
    end
    step(1'b0, 1'b1, 4, 2, '0, 0, 0, '0);
    chk("set4_zero", rd_data, '0);

    // Write-first forwarding on a same-cycle collision.
    step(1'b0, 1'b0, 0, 0, '1, 3, 0, '1);
    step(1'b0, 1'b1, 3, 0, S_MASK'(1), 3, 0, '0);
    chk("fwd_lit", rd_data, {{(S_MASK-1){8'hFF}}, 8'h00});

    // Flush with a read in the same cycle, then a second flush mid-sweep.
    step(1'b0, 1'b0, 0, 0, '1, 7, 2, {S_MASK{8'h5A}});
    step(1'b1, 1'b1, 7, 2, '0, 0, 0, '0);
    chk("flush_read_old", rd_data, {S_MASK{8'h5A}});
    n = 0;
    while (busy && n < 20) begin
      step(n == 2, 1'b0, 0, 0, '0, 0, 0, '0);
      n++;
    end
    chk("flush_len", line_t'(n), line_t'(NUM_SETS));
    step(1'b0, 1'b1, 7, 2, '0, 0, 0, '0);
    chk("flush_cleared", rd_data, '0);

    for (int k = 0; k < 1500; k++) begin
      f  = ($urandom_range(63) == 0);
      rr = 1'($urandom_range(1));
      ri = int'($urandom_range(NUM_SETS - 1));
      rw = int'($urandom_range(NUM_WAYS - 1));
      wi = int'($urandom_range(NUM_SETS - 1));
      ww = int'($urandom_range(NUM_WAYS - 1));
      if ($urandom_range(3) == 0) begin wi = ri; ww = rw; end
      wm = $urandom_range(1) ? '0 : S_MASK'($urandom);
      if ($urandom_range(3) == 0) wm = '1;
      for (int j = 0; j < S_LINE / 32; j++) wd[32*j +: 32] = $urandom;
      step(f, rr, ri, rw, wm, wi, ww, wd);
    end

    // Asynchronous reset between a read's request edge and its next edge.
    step(1'b0, 1'b0, 0, 0, '1, 5, 0, {S_MASK{8'hC3}});
    step(1'b0, 1'b1, 5, 0, '0, 0, 0, '0);
    #2;
    chk_en = 1'b0;
    rst = 1'b0;
    rd_req = 1'b0;
    #1;
    chk("arst_valid", line_t'(rd_valid), '0);
    chk("arst_data", rd_data, '0);
    chk("arst_busy", line_t'(busy), line_t'(1));
    mdl_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 chk_en = 1'b1;
    n = 0;
    while (busy && n < 20) begin idle(); n++; end
    chk("reinit_len", line_t'(n), line_t'(NUM_SETS));
    step(1'b0, 1'b1, 5, 0, '0, 0, 0, '0);
    chk("reinit_zero", rd_data, '0);

    for (int k = 0; k < 200; k++) begin
      rr = 1'($urandom_range(1));
      ri = int'($urandom_range(NUM_SETS - 1));
      rw = int'($urandom_range(NUM_WAYS - 1));
      wm = S_MASK'($urandom);
      for (int j = 0; j < S_LINE / 32; j++) wd[32*j +: 32] = $urandom;
      step(1'b0, rr, ri, rw, wm, ri, int'($urandom_range(NUM_WAYS - 1)), wd);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
